pipelined_mem_stage: RTL
========================

PIPELINED_MEM_STAGE -- requirements
Module: pipelined_mem_stage

Interface
REQ-001 SHALL have ports: Clk  in  1  clock, all state updates on rising edge; reset Clrn, asynchronous, active-low.
REQ-002 SHALL have inputs from EX/MEM register:
- M_valid  1  instruction present.
- M_Wreg  1  register-write enable.
- M_Reg2reg  1  load (write-back selects memory data).
- M_Wmem  1  store.
- M_Alu  32  ALU result / byte address.
- M_Store  32  store data.
- M_write_reg  5  destination register.
REQ-003 SHALL drive outputs to MEM/WB register:
- MEM_Wreg  1.
- MEM_Reg2reg  1.
- MEM_Date_out  32  load data.
- MEM_Alu  32.
- MEM_write_reg  5.
REQ-004 SHALL have control outputs:
- Stall  out  1  freeze PC, IF/ID and EX/MEM.
- Misalign  out  1  one-cycle error pulse.
- Mem_err  out  1  one-cycle timeout pulse.
REQ-005 SHALL have data-memory port:
- Dmem_req  out  1.
- Dmem_we  out  1.
- Dmem_addr  out  32.
- Dmem_wdata  out  32.
- Dmem_rdata  in  32.
- Dmem_ready  in  1  transfer complete this cycle.

Function
REQ-006 SHALL implement FSM states IDLE, WAIT, DONE.
REQ-007 SHALL define mem_op = M_valid & (M_Reg2reg | M_Wmem) & (M_Alu[1:0]==0).
REQ-008 In IDLE with mem_op, SHALL latch address, wdata and we=M_Wmem, set Dmem_req=1 (registered), and go to WAIT.
REQ-009 In WAIT, SHALL hold Dmem_req/addr/wdata/we stable; on Dmem_ready=1 it SHALL drop Dmem_req, latch Dmem_rdata into the load buffer (loads only), and go to DONE.
REQ-010 In DONE, SHALL present outputs for the held instruction and return to IDLE on the next edge.
REQ-011 Stall SHALL be combinational: 1 in IDLE with mem_op, 1 in WAIT, 0 otherwise.
REQ-012 While Stall=1, SHALL force MEM_Wreg=0 and MEM_Reg2reg=0 (bubble into MEM/WB).
REQ-013 Non-memory instructions SHALL pass M_Wreg/M_Reg2reg/M_Alu/M_write_reg combinationally to the outputs with zero added latency, and MEM_Date_out=0.
REQ-014 MEM_Date_out SHALL be the load buffer in DONE for loads, else 0.
REQ-015 Minimum load/store latency SHALL be 3 cycles (IDLE, WAIT, DONE) with Stall high for 2; each extra WAIT cycle SHALL add one.
REQ-016 Dmem_ready in IDLE or DONE SHALL be ignored.
REQ-017 A load/store with M_Alu[1:0]!=0 SHALL issue no request, SHALL pulse Misalign for one cycle (registered, next cycle), and SHALL force MEM_Wreg=0 for that instruction; no stall.
REQ-018 Stores SHALL pass MEM_Wreg=M_Wreg unchanged in DONE.

Reset
REQ-019 When Clrn=0, SHALL immediately force: state=IDLE, Dmem_req=0, Dmem_we=0, Dmem_addr=0, Dmem_wdata=0, load buffer=0, Misalign=0, Mem_err=0, timeout counter=0.
REQ-020 Reset during WAIT SHALL abandon the transfer without a completion cycle.

Configuration
REQ-021 With MEM_TIMEOUT_EN defined, SHALL count WAIT cycles in a 4-bit counter.
- If 16 consecutive WAIT cycles pass without Dmem_ready: drop Dmem_req, go to DONE with load buffer=0, force MEM_Wreg=0 in that DONE cycle, and pulse Mem_err for one cycle.
- The counter SHALL clear on entering WAIT.
REQ-022 Without MEM_TIMEOUT_EN, SHALL wait indefinitely; Mem_err SHALL be tied 0.

Verification
REQ-023 Load, M_Alu=0x10, M_write_reg=5, Dmem_ready in first WAIT cycle with rdata=0x12345678 -> Stall high 2 cycles; DONE cycle: MEM_Date_out=0x12345678, MEM_Wreg=1, MEM_write_reg=5.
REQ-024 Store, M_Alu=0x20, M_Store=0xCAFEF00D, ready after 3 WAIT cycles -> Dmem_we=1, addr=0x20, wdata held 3 cycles, Stall high 4 cycles.
REQ-025 ALU instruction M_Alu=0x7, M_Wreg=1 -> same-cycle MEM_Alu=0x7, MEM_Wreg=1, Stall=0, Dmem_req=0.
REQ-026 Load at M_Alu=0x13 -> no Dmem_req, Misalign=1 next cycle, MEM_Wreg=0.
REQ-027 Clrn=0 in second WAIT cycle -> Dmem_req=0 and Stall=0 immediately, state IDLE; with MEM_TIMEOUT_EN and no ready -> Mem_err pulse after 16 WAIT cycles, MEM_Date_out=0.

Source files
------------

// File: rtl/pipelined_mem_stage_if.sv
// Data-memory bus between the MEM pipeline stage (master) and data memory (slave).
// Handshake: the master raises Dmem_req with Dmem_we/addr/wdata and holds all
// four stable until the slave returns Dmem_ready=1 for one cycle; on that cycle
// the transfer completes (Dmem_rdata is valid for reads) and the master drops
// Dmem_req on the following edge.
interface pipelined_mem_stage_if;
    logic        Dmem_req;
    logic        Dmem_we;
    logic [31:0] Dmem_addr;
    logic [31:0] Dmem_wdata;
    logic [31:0] Dmem_rdata;
    logic        Dmem_ready;

    modport master (
        output Dmem_req, Dmem_we, Dmem_addr, Dmem_wdata,
        input  Dmem_rdata, Dmem_ready
    );

    modport slave (
        input  Dmem_req, Dmem_we, Dmem_addr, Dmem_wdata,
        output Dmem_rdata, Dmem_ready
    );
endinterface

// File: rtl/pipelined_mem_stage.sv
// MEM stage of a 5-stage pipeline with a multi-cycle data-memory port.
// Loads/stores run IDLE -> WAIT (until Dmem_ready) -> DONE and stall the
// upstream pipeline while in flight; ALU instructions pass straight through.
// Optional macro MEM_TIMEOUT_EN: abandon a transfer after 16 WAIT cycles
// without Dmem_ready and pulse Mem_err.
// o_dbg_state exposes the FSM state (0=IDLE, 1=WAIT, 2=DONE).
module pipelined_mem_stage (
    input  logic                         Clk,
    input  logic                         Clrn,
    input  logic                         M_valid,
    input  logic                         M_Wreg,
    input  logic                         M_Reg2reg,
    input  logic                         M_Wmem,
    input  logic [31:0]                  M_Alu,
    input  logic [31:0]                  M_Store,
    input  logic [4:0]                   M_write_reg,
    output logic                         MEM_Wreg,
    output logic                         MEM_Reg2reg,
    output logic [31:0]                  MEM_Date_out,
    output logic [31:0]                  MEM_Alu,
    output logic [4:0]                   MEM_write_reg,
    output logic                         Stall,
    output logic                         Misalign,
    output logic                         Mem_err,
    pipelined_mem_stage_if.master        dmem,
    output logic [1:0]                   o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic        r_req;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_load_buf;
    logic        r_misalign;

    logic        w_is_mem;
    logic        w_aligned;
    logic        w_mem_op;
    logic        w_misalign;
    logic        w_tmo;       // timeout fires this cycle (WAIT only)
    logic        w_tmo_done;  // current DONE cycle ends a timed-out transfer

    assign w_is_mem   = M_valid & (M_Reg2reg | M_Wmem);
    assign w_aligned  = (M_Alu[1:0] == 2'b00);
    assign w_mem_op   = w_is_mem & w_aligned;
    // Only an instruction seen in IDLE is new; WAIT/DONE hold an aligned one.
    assign w_misalign = w_is_mem & ~w_aligned & (r_state == S_IDLE);

`ifdef MEM_TIMEOUT_EN
    logic [3:0] r_tmo_cnt;
    logic       r_mem_err;

    assign w_tmo      = (r_state == S_WAIT) & ~dmem.Dmem_ready & (r_tmo_cnt == 4'hF);
    assign w_tmo_done = r_mem_err & (r_state == S_DONE);
    assign Mem_err    = r_mem_err;

    // Count WAIT cycles; the error flag is high for exactly the DONE cycle after a timeout.
    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            r_tmo_cnt <= 4'd0;
            r_mem_err <= 1'b0;
        end else begin
            r_mem_err <= w_tmo;
            if (r_state == S_IDLE && w_mem_op)
                r_tmo_cnt <= 4'd0;
            else if (r_state == S_WAIT)
                r_tmo_cnt <= r_tmo_cnt + 4'd1;
        end
    end
`else
    assign w_tmo      = 1'b0;
    assign w_tmo_done = 1'b0;
    assign Mem_err    = 1'b0;
`endif

    // State register.
    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    // Next-state logic; Dmem_ready only matters in WAIT.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_mem_op) w_next = S_WAIT;
            S_WAIT:  if (dmem.Dmem_ready || w_tmo) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Stage outputs: bubble while stalled, pass-through otherwise.
    always_comb begin
        Stall         = Clrn & (((r_state == S_IDLE) & w_mem_op) | (r_state == S_WAIT));
        MEM_Wreg      = M_Wreg & ~Stall & ~w_misalign & ~w_tmo_done;
        MEM_Reg2reg   = M_Reg2reg & ~Stall;
        MEM_Alu       = M_Alu;
        MEM_write_reg = M_write_reg;
        MEM_Date_out  = 32'd0;
        if (r_state == S_DONE && !r_we)
            MEM_Date_out = r_load_buf;
    end

    // Memory request registers, load buffer and misalign pulse.
    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            r_req      <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= 32'd0;
            r_wdata    <= 32'd0;
            r_load_buf <= 32'd0;
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= w_misalign;
            case (r_state)
                S_IDLE: begin
                    if (w_mem_op) begin
                        r_req   <= 1'b1;
                        r_we    <= M_Wmem;
                        r_addr  <= M_Alu;
                        r_wdata <= M_Store;
                    end
                end
                S_WAIT: begin
                    if (dmem.Dmem_ready) begin
                        r_req <= 1'b0;
                        if (!r_we)
                            r_load_buf <= dmem.Dmem_rdata;
                    end else if (w_tmo) begin
                        r_req      <= 1'b0;
                        r_load_buf <= 32'd0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dmem.Dmem_req   = r_req;
    assign dmem.Dmem_we    = r_we;
    assign dmem.Dmem_addr  = r_addr;
    assign dmem.Dmem_wdata = r_wdata;
    assign Misalign        = r_misalign;
    assign o_dbg_state     = r_state;

endmodule
